// File: rtl/data_minmax_tracker_if.sv
// Sample stream and frame-summary bundle for data_minmax_tracker.
// The index outputs exist only when MINMAX_INDEX_EN is defined.
interface data_minmax_tracker_if #(
  parameter int unsigned COUNT_W = 8
);
  logic               iValid;
  logic               oReady;
  logic [7:0]         iData;
  logic               iLast;
  logic [2:0]         oCmp;
  logic [7:0]         oMax;
  logic [7:0]         oMin;
  logic [COUNT_W-1:0] oCount;
  logic               oOvf;
  logic               oDone;
  logic               iAck;
`ifdef MINMAX_INDEX_EN
  logic [COUNT_W-1:0] oMaxIdx;
  logic [COUNT_W-1:0] oMinIdx;
`endif

  modport master (
    output iValid, iData, iLast, iAck,
    input  oReady, oCmp, oMax, oMin, oCount, oOvf, oDone
`ifdef MINMAX_INDEX_EN
    , input oMaxIdx, oMinIdx
`endif
  );

  modport slave (
    input  iValid, iData, iLast, iAck,
    output oReady, oCmp, oMax, oMin, oCount, oOvf, oDone
`ifdef MINMAX_INDEX_EN
    , output oMaxIdx, oMinIdx
`endif
  );
endinterface

// File: rtl/data_minmax_tracker.sv
// Per-frame max/min/count tracker with per-sample magnitude code and held summary.
// Define MINMAX_INDEX_EN to add first-occurrence positions of max and min.
module data_minmax_tracker #(
  parameter int unsigned COUNT_W = 8
) (
  input logic                 iClk,
  input logic                 iRst_n,
  data_minmax_tracker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StReport} state_e;

  localparam logic [COUNT_W-1:0] CntMax = '1;

  state_e             r_state, w_state_next;
  logic [7:0]         r_max, w_max_next;
  logic [7:0]         r_min, w_min_next;
  logic [7:0]         r_prev, w_prev_next;
  logic [COUNT_W-1:0] r_count, w_count_next;
  logic               r_ovf, w_ovf_next;
  logic [2:0]         r_cmp, w_cmp_next;
  logic               w_accept;
  logic [2:0]         w_cmp;
`ifdef MINMAX_INDEX_EN
  logic [COUNT_W-1:0] r_max_idx, w_max_idx_next;
  logic [COUNT_W-1:0] r_min_idx, w_min_idx_next;
`endif

  // oReady is held low while reset is asserted.
  assign bus.oReady = iRst_n && (r_state != StReport);
  assign bus.oDone  = (r_state == StReport);
  assign w_accept   = bus.iValid && bus.oReady;

  assign w_cmp = (bus.iData > r_prev)  ? 3'b100 :
                 (bus.iData == r_prev) ? 3'b010 : 3'b001;

  always_comb begin
    w_state_next = r_state;
    w_max_next   = r_max;
    w_min_next   = r_min;
    w_prev_next  = r_prev;
    w_count_next = r_count;
    w_ovf_next   = r_ovf;
    w_cmp_next   = r_cmp;
`ifdef MINMAX_INDEX_EN
    w_max_idx_next = r_max_idx;
    w_min_idx_next = r_min_idx;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_max_next   = bus.iData;
          w_min_next   = bus.iData;
          w_prev_next  = bus.iData;
          w_count_next = {{(COUNT_W-1){1'b0}}, 1'b1};
          w_ovf_next   = 1'b0;
          w_cmp_next   = 3'b000;
`ifdef MINMAX_INDEX_EN
          w_max_idx_next = '0;
          w_min_idx_next = '0;
`endif
          w_state_next = bus.iLast ? StReport : StAccum;
        end
      end
      StAccum: begin
        if (w_accept) begin
          w_prev_next = bus.iData;
          w_cmp_next  = w_cmp;
          if (bus.iData > r_max) begin
            w_max_next = bus.iData;
`ifdef MINMAX_INDEX_EN
            w_max_idx_next = r_count;  // old count is this beat's zero-based position
`endif
          end
          if (bus.iData < r_min) begin
            w_min_next = bus.iData;
`ifdef MINMAX_INDEX_EN
            w_min_idx_next = r_count;
`endif
          end
          if (r_count == CntMax) w_ovf_next = 1'b1;
          else                   w_count_next = r_count + 1'b1;
          if (bus.iLast) w_state_next = StReport;
        end
      end
      StReport: begin
        if (bus.iAck) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= StIdle;
      r_max   <= '0;
      r_min   <= '0;
      r_prev  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_cmp   <= 3'b000;
`ifdef MINMAX_INDEX_EN
      r_max_idx <= '0;
      r_min_idx <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_max   <= w_max_next;
      r_min   <= w_min_next;
      r_prev  <= w_prev_next;
      r_count <= w_count_next;
      r_ovf   <= w_ovf_next;
      r_cmp   <= w_cmp_next;
`ifdef MINMAX_INDEX_EN
      r_max_idx <= w_max_idx_next;
      r_min_idx <= w_min_idx_next;
`endif
    end
  end

  assign bus.oMax   = r_max;
  assign bus.oMin   = r_min;
  assign bus.oCount = r_count;
  assign bus.oOvf   = r_ovf;
  assign bus.oCmp   = r_cmp;
`ifdef MINMAX_INDEX_EN
  assign bus.oMaxIdx = r_max_idx;
  assign bus.oMinIdx = r_min_idx;
`endif

endmodule

// File: tb/tb_data_minmax_tracker.sv
// Directed self-checking bench for data_minmax_tracker.
module tb_data_minmax_tracker;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  data_minmax_tracker_if #(.COUNT_W(8)) bus ();

  data_minmax_tracker #(.COUNT_W(8)) u_dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Presents one sample, waits (bounded) for acceptance, returns 1 tick after the edge.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int t = 0;
    bus.iValid = 1'b1;
    bus.iData  = d;
    bus.iLast  = last;
    while (!bus.oReady && t < 50) begin
      tick();
      t++;
    end
    check_eq("beat_ready_timeout", 32'(t < 50), 32'd1);
    tick();
    bus.iValid = 1'b0;
    bus.iLast  = 1'b0;
  endtask

  task automatic ack_frame();
    int t = 0;
    while (!bus.oDone && t < 50) begin
      tick();
      t++;
    end
    check_eq("ack_done_timeout", 32'(t < 50), 32'd1);
    bus.iAck = 1'b1;
    tick();
    bus.iAck = 1'b0;
  endtask

  task automatic check_summary(input string tag, input logic [7:0] mx, input logic [7:0] mn,
                               input logic [7:0] cnt, input logic ovf);
    check_eq({tag, "_done"}, 32'(bus.oDone), 32'd1);
    check_eq({tag, "_max"},  32'(bus.oMax),  32'(mx));
    check_eq({tag, "_min"},  32'(bus.oMin),  32'(mn));
    check_eq({tag, "_cnt"},  32'(bus.oCount), 32'(cnt));
    check_eq({tag, "_ovf"},  32'(bus.oOvf),  32'(ovf));
  endtask

  logic [7:0] frame_a [5] = '{8'd5, 8'd9, 8'd3, 8'd9, 8'd1};
  logic [2:0] cmp_a   [5] = '{3'b000, 3'b100, 3'b001, 3'b100, 3'b001};
  logic [7:0] frame_g [3] = '{8'h00, 8'hFF, 8'h80};

  initial begin
    bus.iValid = 1'b0;
    bus.iData  = '0;
    bus.iLast  = 1'b0;
    bus.iAck   = 1'b0;

    // Reset state
    #1;
    check_eq("rst_ready", 32'(bus.oReady), 32'd0);
    check_eq("rst_done",  32'(bus.oDone),  32'd0);
    check_eq("rst_max",   32'(bus.oMax),   32'd0);
    check_eq("rst_min",   32'(bus.oMin),   32'd0);
    check_eq("rst_cnt",   32'(bus.oCount), 32'd0);
    check_eq("rst_ovf",   32'(bus.oOvf),   32'd0);
    check_eq("rst_cmp",   32'(bus.oCmp),   32'd0);
    tick();
    tick();
    iRst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(bus.oReady), 32'd1);

    // Frame 5,9,3,9,1
    for (int i = 0; i < 5; i++) begin
      send_beat(frame_a[i], i == 4);
      check_eq($sformatf("a_cmp%0d", i), 32'(bus.oCmp), 32'(cmp_a[i]));
    end
    check_summary("a", 8'd9, 8'd1, 8'd5, 1'b0);
`ifdef MINMAX_INDEX_EN
    check_eq("a_max_idx", 32'(bus.oMaxIdx), 32'd1);
    check_eq("a_min_idx", 32'(bus.oMinIdx), 32'd4);
`endif

    // Hold REPORT with a pending sample, no ack
    bus.iValid = 1'b1;
    bus.iData  = 8'h33;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold_ready", 32'(bus.oReady), 32'd0);
    end
    check_summary("hold", 8'd9, 8'd1, 8'd5, 1'b0);
    check_eq("hold_cmp", 32'(bus.oCmp), 32'b001);
    bus.iValid = 1'b0;
    bus.iAck   = 1'b1;
    tick();
    bus.iAck = 1'b0;
    check_eq("ack_done",  32'(bus.oDone),  32'd0);
    check_eq("ack_ready", 32'(bus.oReady), 32'd1);
    check_eq("ack_keep_max", 32'(bus.oMax), 32'd9);
    tick();
    check_eq("idle_no_beat_cnt", 32'(bus.oCount), 32'd5);

    // Single-beat frame
    send_beat(8'h7F, 1'b1);
    check_summary("single", 8'h7F, 8'h7F, 8'd1, 1'b0);
    check_eq("single_cmp", 32'(bus.oCmp), 32'd0);
    ack_frame();

    // 300 equal beats at full rate: counter saturates
    for (int i = 0; i < 300; i++) begin
      send_beat(8'hAA, i == 299);
      if (i == 1) check_eq("sat_cmp_b2", 32'(bus.oCmp), 32'b010);
      if (i == 254) begin
        check_eq("sat_cnt255", 32'(bus.oCount), 32'd255);
        check_eq("sat_ovf_at255", 32'(bus.oOvf), 32'd0);
      end
      if (i == 255) check_eq("sat_ovf_256", 32'(bus.oOvf), 32'd1);
    end
    check_summary("sat", 8'hAA, 8'hAA, 8'd255, 1'b1);
    check_eq("sat_cmp", 32'(bus.oCmp), 32'b010);
    ack_frame();

    // Reset mid-frame
    send_beat(8'd50, 1'b0);
    send_beat(8'd60, 1'b0);
    send_beat(8'd70, 1'b0);
    iRst_n = 1'b0;
    #1;
    check_eq("mid_rst_cnt",   32'(bus.oCount), 32'd0);
    check_eq("mid_rst_done",  32'(bus.oDone),  32'd0);
    check_eq("mid_rst_ready", 32'(bus.oReady), 32'd0);
    tick();
    iRst_n = 1'b1;
    #1;
    send_beat(8'd2, 1'b0);
    send_beat(8'd4, 1'b1);
    check_summary("after_rst", 8'd4, 8'd2, 8'd2, 1'b0);
    check_eq("after_rst_cmp", 32'(bus.oCmp), 32'b100);
    ack_frame();

    // Frame with random idle gaps
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_beat(frame_g[i], i == 2);
    end
    check_summary("gaps", 8'hFF, 8'h00, 8'd3, 1'b0);
    check_eq("gaps_cmp", 32'(bus.oCmp), 32'b001);
`ifdef MINMAX_INDEX_EN
    check_eq("gaps_max_idx", 32'(bus.oMaxIdx), 32'd1);
    check_eq("gaps_min_idx", 32'(bus.oMinIdx), 32'd0);
`endif
    ack_frame();
    check_eq("final_done", 32'(bus.oDone), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/data_minmax_tracker.md
# data_minmax_tracker

Streaming stage that consumes a frame of 8-bit samples over a valid/ready handshake and reports the frame's maximum, minimum and sample count. It also emits a registered 3-bit magnitude code for each sample against its predecessor, using the one-hot greater/equal/less encoding of the 8-bit comparator. It sits directly downstream of the sample source and feeds the result/display logic. A result handshake holds the frame summary until the consumer acknowledges it.

## Interface
- COUNT_W, 8, width of sample counter (frame length field)
- iClk  in  1  system clock, rising edge
- iRst_n  in  1  asynchronous active-low reset
- iValid  in  1  sample present on iData
- oReady  out  1  stage accepts a sample this cycle
- iData  in  8  unsigned sample
- iLast  in  1  qualifies the accepted sample as the last of its frame
- oCmp  out  3  code of last accepted sample vs previous sample in frame: 100 greater, 010 equal, 001 less, 000 first sample
- oMax  out  8  running/final maximum
- oMin  out  8  running/final minimum
- oCount  out  COUNT_W  samples accepted in frame, saturating
- oOvf  out  1  sticky: count saturated in this frame
- oDone  out  1  frame summary valid
- iAck  in  1  consumer takes summary while oDone=1

## Operation
- Beat accepted when iValid=1 and oReady=1 at a rising iClk edge; all other cycles ignore iData/iLast.
- States: IDLE (no sample of current frame yet), ACCUM (≥1 sample accepted), REPORT (summary held).
- IDLE: oReady=1. Accepted beat: oMax=oMin=iData, oCount=1, oOvf=0, oCmp=000. Go to REPORT if iLast, else ACCUM.
- ACCUM: oReady=1. Accepted beat: oMax updates only if iData > oMax; oMin only if iData < oMin; oCount+1 saturating at 2^COUNT_W-1 (saturation sets oOvf). oCmp = compare of iData vs previous accepted sample. Go to REPORT if iLast.
- REPORT: oReady=0, oDone=1, oMax/oMin/oCount/oOvf/oCmp frozen. iAck=1 -> IDLE next cycle. iAck outside REPORT is ignored.
- Summary registers hold their values after leaving REPORT until the first beat of the next frame overwrites them.
- Comparisons are unsigned 8-bit; equal values never update max/min.

## Timing
- Reset (iRst_n=0, asynchronous): state IDLE, oReady=1 after release (0 while asserted), oMax=0, oMin=0, oCount=0, oOvf=0, oCmp=000, oDone=0, index outputs 0.
- oMax/oMin/oCount/oCmp reflect an accepted beat on the cycle after its edge (1-cycle latency).
- oDone rises on the cycle after the iLast beat; it falls on the cycle after the iAck edge. oReady is 0 for at least one cycle per frame (≥1 bubble between frames).
- Single-beat frame (iLast on first beat): IDLE -> REPORT directly, count=1, max=min=sample.
- Back-to-back beats at full rate sustained within a frame; no throughput loss until iLast.
- Reset mid-frame or in REPORT discards the frame; no oDone is produced for it.
- Counter wrap: never wraps; at 255 (COUNT_W=8) further beats leave oCount=255 and set oOvf.

## Configuration
- MINMAX_INDEX_EN defined: adds outputs oMaxIdx and oMinIdx (COUNT_W each). Each holds the zero-based position of the first occurrence of the current max/min in the frame, updated with oMax/oMin, frozen in REPORT, and reset to 0. Positions follow the saturating counter.
- Not defined: ports and logic absent; behaviour otherwise identical.

## Test plan
- Reset then frame 5,9,3,9,1 with iLast on 1 -> oDone=1, oMax=9, oMin=1, oCount=5, oOvf=0; oCmp sequence 000,100,001,100,001; with MINMAX_INDEX_EN, oMaxIdx=1, oMinIdx=4.
- Single beat 0x7F with iLast -> next cycle oDone=1, oMax=oMin=0x7F, oCount=1, oCmp=000.
- Hold iAck=0 for 10 cycles in REPORT with iValid=1 -> oReady=0, summary unchanged. iAck=1 -> oDone=0 and oReady=1 next cycle. The next frame starts cleanly.
- 300-beat frame of 0xAA at full rate -> oCount=255, oOvf=1, oMax=oMin=0xAA, oCmp=010 after beat 2.
- Assert iRst_n low mid-frame after 3 beats, release, send 2,4 with iLast -> oMax=4, oMin=2, oCount=2; no stale values from the aborted frame.
- Random iValid gaps over frame 0x00,0xFF,0x80 -> results identical to the gap-free run (max 0xFF, min 0x00, count 3).
